// File: rtl/pc_stack.sv
// pc_stack: program counter with an integrated return-address stack.
// Each cycle it performs at most one operation, in priority order
// load > call > ret > rel > inc > hold.
//
// Ports
//   clk, rst  : rising-edge clock; asynchronous active-high reset
//   in        : absolute target for load and call
//   off       : two's-complement offset for rel
//   load/call/ret/rel/inc : operation requests, sampled at each edge
//   out       : current PC (registered)
//   sp        : number of valid stack entries (registered)
//   full      : asserted when sp == DEPTH
//   empty     : asserted when sp == 0
//   err       : sticky overflow/underflow flag, cleared only by rst
module pc_stack #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int STEP  = 1,
  localparam int SPW  = $clog2(DEPTH+1),
  localparam int IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  input  logic [WIDTH-1:0] off,
  input  logic             load,
  input  logic             call,
  input  logic             ret,
  input  logic             rel,
  input  logic             inc,
  output logic [WIDTH-1:0] out,
  output logic [SPW-1:0]   sp,
  output logic             full,
  output logic             empty,
  output logic             err
);

  // Stack storage is not reset. Entries at or above sp are never read.
  logic [WIDTH-1:0] stk [DEPTH];

  logic [WIDTH-1:0] out_nx;
  logic [SPW-1:0]   sp_nx;
  logic             err_nx;
  logic             push;
  logic [WIDTH-1:0] ra;
  logic [SPW-1:0]   spm1;

  assign full  = (sp == SPW'(DEPTH));
  assign empty = (sp == '0);

  // Return address wraps modulo 2^WIDTH, like every other PC update.
  assign ra   = out + WIDTH'(STEP);
  assign spm1 = sp - SPW'(1);

  always_comb begin
    out_nx = out;
    sp_nx  = sp;
    err_nx = err;
    push   = 1'b0;
    if (load) begin
      out_nx = in;
    end else if (call) begin
      if (full) begin
        err_nx = 1'b1;
      end else begin
        push   = 1'b1;
        sp_nx  = sp + SPW'(1);
        out_nx = in;
      end
    end else if (ret) begin
      if (empty) begin
        err_nx = 1'b1;
      end else begin
        // sp-1 < DEPTH here, so the low IW bits address the entry.
        out_nx = stk[spm1[IW-1:0]];
        sp_nx  = spm1;
      end
    end else if (rel) begin
      out_nx = out + off;
    end else if (inc) begin
      out_nx = out + WIDTH'(STEP);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out <= '0;
      sp  <= '0;
      err <= 1'b0;
    end else begin
      out <= out_nx;
      sp  <= sp_nx;
      err <= err_nx;
    end
  end

  // Push only when not full, so sp < DEPTH and fits in IW bits.
  // Gated by rst so requests held during reset leave no trace.
  always_ff @(posedge clk) begin
    if (push && !rst) stk[sp[IW-1:0]] <= ra;
  end

endmodule

// File: doc/pc_stack.md
# pc_stack

Parametrised program counter with an integrated hardware return-address stack. It extends the plain load/increment/reset counter with a configurable width and step, relative branching, and call/return handling. It also reports stack occupancy and errors. It sits at the front of the instruction-fetch path and drives the instruction-memory address every cycle.

## Interface

Parameters:
- WIDTH, 16, bit width of the PC, `in`, `off` and each stack entry
- DEPTH, 8, number of return-address entries (≥ 2)
- STEP, 1, increment applied by `inc` and used to form the return address on `call`

Ports:
- clk  in  1  rising-edge clock, the single clock of the block
- rst  in  1  asynchronous, active-high reset
- in  in  WIDTH  absolute target for `load` and `call`
- off  in  WIDTH  two's-complement offset for `rel`
- load  in  1  absolute jump: out ← in
- call  in  1  push return address, then jump to `in`
- ret  in  1  pop the stack into the PC
- rel  in  1  relative branch: out ← out + off
- inc  in  1  sequential advance: out ← out + STEP
- out  out  WIDTH  current PC, registered
- sp  out  $clog2(DEPTH+1)  number of valid stack entries, registered
- full  out  1  sp == DEPTH
- empty  out  1  sp == 0
- err  out  1  sticky overflow/underflow flag, registered

## Operation

- One operation per cycle. Fixed priority: load > call > ret > rel > inc > hold.
- Lower-priority requests asserted in the same cycle are ignored; they are not queued.
- **load:** out ← in. Stack unchanged.
- **call, not full:**
  - stack[sp] ← out + STEP
  - sp ← sp + 1
  - out ← in
- **call, full:**
  - No push and no jump: out and sp are held.
  - err ← 1.
- **ret, not empty:**
  - out ← stack[sp−1]
  - sp ← sp − 1
- **ret, empty:**
  - out and sp are held.
  - err ← 1.
- **rel:** out ← out + off. Full WIDTH-bit addition, result truncated modulo 2^WIDTH (wraps both directions).
- **inc:** out ← out + STEP, modulo 2^WIDTH. Example: 0xFFFF + 1 = 0x0000 at WIDTH = 16.
- **hold:** no request asserted; all state is kept.
- Return-address arithmetic also wraps: a call at out = 0xFFFF with STEP = 1 pushes 0x0000.
- `full` and `empty` are combinational decodes of the registered `sp`, so they carry no extra latency.
- `err` is cleared only by `rst`; no other input clears it.
- Stack storage is an array of registers with no reset. Entries at or above `sp` are don't-care and never appear on any output.

## Timing

- Asynchronous reset: asserting `rst` immediately forces out = 0, sp = 0, err = 0, which gives full = 0 and empty = 1. No clock edge is required.
- While `rst` is held, all requests are ignored.
- On `rst` deassertion, the first rising edge with a request acts normally.
- Reset during an operation (for example, rst rising between a call request and the next edge) discards that operation; the stack is logically emptied.
- Latency: each request is sampled at a rising edge, and its result is visible on `out`, `sp` and `err` immediately after that edge (one cycle).
- Back-to-back operations are supported every cycle with no bubbles:
  - call followed by ret returns to the call address + STEP.
  - ret immediately after a push reads the just-written entry.
- Request inputs must be stable around the rising edge. There is no handshake; requests are level-sampled at each edge, so holding `inc` high for N edges advances the PC by N·STEP.

## Test plan

- **Reset/load/inc:**
  - Pulse rst → out=0, sp=0, empty=1, err=0 before any clk edge.
  - load in=0x0010 → out=0x0010.
  - inc held for 3 edges → out=0x0013.
- **Priority:**
  - load=1, call=1, inc=1, in=0x0200 → out=0x0200, sp unchanged.
  - call=1 and ret=1 with sp=0, in=0x0300, out=0x0013 → push 0x0014, out=0x0300, sp=1.
- **Nested call/return (DEPTH=8):**
  - Starting from out=0x0100, 8 calls to targets 0x1000 + 16·k (k = 0..7) → full=1, sp=8.
  - 8 returns → out values in order: last return address pushed down to 0x0101; finally empty=1, err=0.
- **Overflow/underflow:**
  - Call while full → out and sp unchanged, err=1.
  - err stays 1 across later valid ops.
  - ret while empty after rst → out held, err=1.
- **Wrap-around:**
  - out=0xFFFF, inc → 0x0000.
  - out=0x0002, rel off=0xFFFC (−4) → 0xFFFE.
  - out=0xFFFE, rel off=0x0005 → 0x0003.
  - call at out=0xFFFF pushes 0x0000.
- **Async reset mid-sequence:**
  - After 3 pushes, assert rst between edges → out=0, sp=0, err=0 at once.
  - Following ret → err=1, out=0.
